// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the MIPS pipeline front end: next-PC encodings,
// reset/boot constants and the IF/ID pipeline register payload.
package cpu_defs_pkg;

    localparam int unsigned XLEN = 32;

    // Next-PC source selected by the decode stage
    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    localparam logic [XLEN-1:0] CPU_RESET_PC  = 32'h0000_3000;
    localparam logic [XLEN-1:0] CPU_NOP_INSTR = 32'h0000_0000;
    localparam int unsigned     CPU_IM_WORDS  = 4096;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc8;
        logic            valid;
        logic            adel;
    } ifid_t;

endpackage

// File: rtl/if_stage_npc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch,
// pseudo-direct jump or register jump. Branch/jump targets are relative to
// the instruction in ID (the delay-slot predecessor), not to F_pc.
module npc_calc
    import cpu_defs_pkg::*;
(
    input  logic [XLEN-1:0] i_f_pc,
    input  logic [XLEN-1:0] i_d_pc,
    input  logic [1:0]      i_npc_sel,
    input  logic [15:0]     i_br_imm16,
    input  logic [25:0]     i_j_index,
    input  logic [XLEN-1:0] i_jr_target,
    output logic [XLEN-1:0] o_npc_c
);

    logic [XLEN-1:0] w_d_pc_plus4;
    logic [XLEN-1:0] w_br_off;

    assign w_d_pc_plus4 = i_d_pc + 32'd4;
    assign w_br_off     = {{14{i_br_imm16[15]}}, i_br_imm16, 2'b00};

    // Pick the next fetch address; all adds wrap modulo 2^32
    always_comb begin
        o_npc_c = i_f_pc + 32'd4;
        unique case (npc_sel_e'(i_npc_sel))
            NPC_SEQ: o_npc_c = i_f_pc + 32'd4;
            NPC_BR:  o_npc_c = w_d_pc_plus4 + w_br_off;
            NPC_J:   o_npc_c = {w_d_pc_plus4[31:28], i_j_index, 2'b00};
            NPC_JR:  o_npc_c = i_jr_target;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address and registers the fetched word into the IF/ID register, honouring
// stall/flush from the hazard unit and redirects from ID.
module if_stage
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
    parameter int unsigned IM_WORDS  = CPU_IM_WORDS,
    parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] br_imm16,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        F_adel,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc8,
    output logic        D_valid,
    output logic        D_adel
);

    // End of the legal fetch window, computed in 33 bits so it cannot wrap
    localparam logic [32:0] IM_END = 33'(RESET_PC) + 33'(IM_WORDS) * 33'd4;

    logic [31:0] r_f_pc;
    ifid_t       r_d;
    logic [31:0] w_npc;
    logic        w_adel;

    npc_calc u_npc_calc (
        .i_f_pc      (r_f_pc),
        .i_d_pc      (r_d.pc),
        .i_npc_sel   (npc_sel),
        .i_br_imm16  (br_imm16),
        .i_j_index   (j_index),
        .i_jr_target (jr_target),
        .o_npc_c     (w_npc)
    );

    // Fetch address error: misaligned or outside instruction memory
    always_comb begin
        w_adel = (r_f_pc[1:0] != 2'b00)
               | (r_f_pc < RESET_PC)
               | ({1'b0, r_f_pc} >= IM_END);
    end

    // PC register and IF/ID register; reset beats stall, stall beats flush
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_f_pc    <= RESET_PC;
            r_d.instr <= NOP_INSTR;
            r_d.pc    <= RESET_PC;
            r_d.pc8   <= RESET_PC + 32'd8;
            r_d.valid <= 1'b0;
            r_d.adel  <= 1'b0;
        end else if (!stall) begin
            r_f_pc  <= w_npc;
            r_d.pc  <= r_f_pc;
            r_d.pc8 <= r_f_pc + 32'd8;
            if (flush) begin
                r_d.instr <= NOP_INSTR;
                r_d.valid <= 1'b0;
                r_d.adel  <= 1'b0;
            end else begin
                r_d.instr <= w_adel ? NOP_INSTR : imem_data;
                r_d.valid <= 1'b1;
                r_d.adel  <= w_adel;
            end
        end
    end

    assign imem_addr = r_f_pc;
    assign F_adel    = w_adel;
    assign D_instr   = r_d.instr;
    assign D_pc      = r_d.pc;
    assign D_pc8     = r_d.pc8;
    assign D_valid   = r_d.valid;
    assign D_adel    = r_d.adel;

endmodule
